// File: rtl/muldiv_sequencer_if.sv
// Request/response port between the E stage and the M-extension sequencer.
// The master (E stage) issues one operation and later accepts its result.
`timescale 1ns/1ps
interface muldiv_sequencer_if #(
  parameter int WIDTH_DATA = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [WIDTH_DATA-1:0] req_a;
  logic [WIDTH_DATA-1:0] req_b;
  logic [4:0]            req_rd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH_DATA-1:0] rsp_data;
  logic [4:0]            rsp_rd;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one RV32 M-extension operation through the multiplier or divider,
// resolving divide-by-zero and signed overflow locally, and returns one result.
`timescale 1ns/1ps
module muldiv_sequencer #(
  parameter int WIDTH_DATA = 32,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  muldiv_sequencer_if.slave     bus,
  input  logic                  flush,
  output logic [WIDTH_DATA-1:0] op_a,
  output logic [WIDTH_DATA-1:0] op_b,
  output logic                  mul_start,
  output logic [1:0]            mul_unsigned,
  input  logic [WIDTH_DATA-1:0] mul_high,
  input  logic [WIDTH_DATA-1:0] mul_low,
  output logic                  div_start,
  output logic                  div_unsigned,
  input  logic [WIDTH_DATA-1:0] quotient,
  input  logic [WIDTH_DATA-1:0] remainder,
  output logic                  stall
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH_DATA-1:0] MIN_NEG = {1'b1, {(WIDTH_DATA-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      count_q;
  logic [1:0]            op_sel_q;
  logic [WIDTH_DATA-1:0] rsp_data_q;
  logic [4:0]            rsp_rd_q;

  logic                  accept;
  logic                  req_is_mul;
  logic                  div_by_zero;
  logic                  div_overflow;
  logic                  div_special;
  logic [WIDTH_DATA-1:0] special_result;
  logic [WIDTH_DATA-1:0] unit_result;

  // Request decode: op[2] selects the divider, op[1] remainder, op[0] unsigned.
  always_comb begin
    accept       = (state_q == IDLE) && bus.req_valid && !flush;
    req_is_mul   = ~bus.req_op[2];
    div_by_zero  = (bus.req_b == '0);
    div_overflow = ~bus.req_op[0] && (bus.req_a == MIN_NEG) && (bus.req_b == '1);
    div_special  = ~req_is_mul && (div_by_zero || div_overflow);
    if (div_by_zero) begin
      special_result = bus.req_op[1] ? bus.req_a : '1;
    end else begin
      special_result = bus.req_op[1] ? '0 : MIN_NEG;
    end
    if (state_q == MUL_RUN) begin
      unit_result = (op_sel_q == 2'b00) ? mul_low : mul_high;
    end else begin
      unit_result = op_sel_q[1] ? remainder : quotient;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (req_is_mul)       state_d = MUL_RUN;
            else if (div_special) state_d = DONE;
            else                  state_d = DIV_RUN;
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (count_q == '0) state_d = DONE;
        end
        DONE: begin
          if (bus.rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The counter still holds its load value only during the cycle right after
  // acceptance, which is what makes each start a single-cycle pulse.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == DONE);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_rd    = rsp_rd_q;
    mul_start     = (state_q == MUL_RUN) && (count_q == MUL_CNT) && !flush;
    div_start     = (state_q == DIV_RUN) && (count_q == DIV_CNT) && !flush;
    stall         = ((state_q == IDLE) && bus.req_valid)
                  || (state_q == MUL_RUN) || (state_q == DIV_RUN)
                  || ((state_q == DONE) && !bus.rsp_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      op_sel_q     <= 2'b00;
      op_a         <= '0;
      op_b         <= '0;
      rsp_data_q   <= '0;
      rsp_rd_q     <= 5'd0;
      mul_unsigned <= 2'b00;
      div_unsigned <= 1'b0;
    end else if (flush) begin
      count_q <= '0;
    end else if (accept) begin
      op_a         <= bus.req_a;
      op_b         <= bus.req_b;
      op_sel_q     <= bus.req_op[1:0];
      rsp_rd_q     <= bus.req_rd;
      mul_unsigned <= {bus.req_op == 3'd3, (bus.req_op == 3'd2) || (bus.req_op == 3'd3)};
      div_unsigned <= bus.req_op[2] & bus.req_op[0];
      count_q      <= req_is_mul ? MUL_CNT : DIV_CNT;
      if (div_special) rsp_data_q <= special_result;
    end else if ((state_q == MUL_RUN) || (state_q == DIV_RUN)) begin
      if (count_q == '0) begin
        rsp_data_q <= unit_result;
      end else begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-built
// flush/reset sequences and randomized operations against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
  localparam int W       = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [W-1:0] op_a, op_b, mul_high, mul_low, quotient, remainder;
  logic mul_start, div_start, div_unsigned, stall;
  logic [1:0] mul_unsigned;

  int compared = 0;
  int mismatched = 0;
  int mul_starts = 0;
  int div_starts = 0;
  logic [1:0] last_mul_uns = 2'b00;
  logic last_div_uns = 1'b0;

  muldiv_sequencer_if #(.WIDTH_DATA(W)) bus ();

  muldiv_sequencer #(.WIDTH_DATA(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .op_a(op_a), .op_b(op_b),
    .mul_start(mul_start), .mul_unsigned(mul_unsigned),
    .mul_high(mul_high), .mul_low(mul_low),
    .div_start(div_start), .div_unsigned(div_unsigned),
    .quotient(quotient), .remainder(remainder),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // Stand-in units: results are only correct in the exact cycle the latency promises.
  function automatic logic [63:0] unit_mul(logic [31:0] a, logic [31:0] b, logic [1:0] uns);
    logic [63:0] ea, eb;
    ea = uns[1] ? {32'b0, a} : {{32{a[31]}}, a};
    eb = uns[0] ? {32'b0, b} : {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  logic [63:0] mprod;
  logic [31:0] dq, dr;
  int mcnt, dcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0;
      dcnt <= 0;
    end else begin
      if (mul_start) begin
        mprod <= unit_mul(op_a, op_b, mul_unsigned);
        mcnt  <= 1;
      end else if (mcnt != 0 && mcnt <= MUL_LAT) begin
        mcnt <= mcnt + 1;
      end
      if (div_start) begin
        if (op_b == 32'd0) begin
          dq <= 32'hDEAD_BEEF;
          dr <= 32'hDEAD_BEEF;
        end else if (div_unsigned) begin
          dq <= op_a / op_b;
          dr <= op_a % op_b;
        end else begin
          dq <= 32'(longint'($signed(op_a)) / longint'($signed(op_b)));
          dr <= 32'(longint'($signed(op_a)) % longint'($signed(op_b)));
        end
        dcnt <= 1;
      end else if (dcnt != 0 && dcnt <= DIV_LAT) begin
        dcnt <= dcnt + 1;
      end
    end
  end
  assign mul_high  = (mcnt == MUL_LAT) ? mprod[63:32] : 32'hDEAD_BEEF;
  assign mul_low   = (mcnt == MUL_LAT) ? mprod[31:0]  : 32'hBAD0_0BAD;
  assign quotient  = (dcnt == DIV_LAT) ? dq : 32'hDEAD_BEEF;
  assign remainder = (dcnt == DIV_LAT) ? dr : 32'hBAD0_0BAD;

  always @(posedge clk) begin
    if (mul_start) begin
      mul_starts++;
      last_mul_uns = mul_unsigned;
    end
    if (div_start) begin
      div_starts++;
      last_div_uns = div_unsigned;
    end
  end

  // Reference model: RISC-V M-extension results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[2]) return MUL_LAT + 2;
    if (b == 0) return 1;
    if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT + 2;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rd    = rd;
  endtask

  task automatic check_reset_state(input string name);
    check_output({name, ".ctrl"},
                 {bus.req_ready, stall, mul_start, div_start, bus.rsp_valid, bus.rsp_rd,
                  mul_unsigned, div_unsigned}, {51'b0, 1'b1, 12'b0});
    check_output({name, ".ops"}, {op_a, op_b}, 64'd0);
    check_output({name, ".rsp_data"}, {32'b0, bus.rsp_data}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                        input int exp_lat, input int hold);
    int ms0, ds0, lat;
    bit stall_ok;
    bit exp_div;
    ms0 = mul_starts;
    ds0 = div_starts;
    stall_ok = 1'b1;
    exp_div = op[2] && (exp_lat != 1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    apply_stimulus(op, a, b, rd);
    #1;
    check_output({name, ".accept"}, {62'b0, bus.req_ready, stall}, 64'd3);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom);
    bus.req_a  = $urandom;
    bus.req_b  = $urandom;
    bus.req_rd = 5'($urandom);
    while (!bus.rsp_valid && lat < 200) begin
      if (!stall) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_output({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check_output({name, ".stall_busy"}, {63'b0, stall_ok}, 64'd1);
    check_output({name, ".rsp_data"}, {32'b0, bus.rsp_data}, {32'b0, exp_data});
    check_output({name, ".rsp_rd"}, {59'b0, bus.rsp_rd}, {59'b0, rd});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output({name, ".hold"}, {25'b0, bus.rsp_valid, stall, bus.rsp_data, bus.rsp_rd},
                   {25'b0, 1'b1, 1'b1, exp_data, rd});
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_output({name, ".stall_release"}, {63'b0, stall}, 64'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_output({name, ".back_idle"}, {62'b0, bus.rsp_valid, bus.req_ready}, 64'd1);
    check_output({name, ".starts"}, {32'(mul_starts - ms0), 32'(div_starts - ds0)},
                 {32'(op[2] ? 0 : 1), 32'(exp_div ? 1 : 0)});
    if (!op[2]) begin
      check_output({name, ".mul_unsigned"}, {62'b0, last_mul_uns},
                   {62'b0, op == 3'd3, (op == 3'd2) || (op == 3'd3)});
    end
    if (exp_div) begin
      check_output({name, ".div_unsigned"}, {63'b0, last_div_uns}, {63'b0, op[0]});
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t vecs[15];

  initial begin
    watchdog();
  end

  task automatic watchdog();
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  endtask

  initial begin
    int ms0, seen;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT + 2, 0};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, MUL_LAT + 2, 0};
    vecs[2]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         5'd3,  32'hFFFF_FFFA, DIV_LAT + 2, 0};
    vecs[3]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         5'd4,  32'hFFFF_FFFE, DIV_LAT + 2, 0};
    vecs[4]  = '{3'd5, 32'd5,          32'd0,         5'd5,  32'hFFFF_FFFF, 1,           0};
    vecs[5]  = '{3'd6, MIN_NEG,        32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1,           0};
    vecs[6]  = '{3'd4, MIN_NEG,        32'hFFFF_FFFF, 5'd7,  MIN_NEG,       1,           0};
    vecs[7]  = '{3'd7, 32'd5,          32'd0,         5'd8,  32'd5,         1,           0};
    vecs[8]  = '{3'd1, MIN_NEG,        MIN_NEG,       5'd9,  32'h4000_0000, MUL_LAT + 2, 0};
    vecs[9]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, MUL_LAT + 2, 5};
    vecs[10] = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        DIV_LAT + 2, 0};
    vecs[11] = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         DIV_LAT + 2, 5};
    vecs[12] = '{3'd4, 32'd7,          32'd0,         5'd13, 32'hFFFF_FFFF, 1,           0};
    vecs[13] = '{3'd7, MIN_NEG,        32'hFFFF_FFFF, 5'd14, MIN_NEG,       DIV_LAT + 2, 0};
    vecs[14] = '{3'd5, MIN_NEG,        32'hFFFF_FFFF, 5'd15, 32'd0,         DIV_LAT + 2, 0};

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.req_rd    = 5'd0;
    bus.rsp_ready = 1'b0;
    #1;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp_data, vecs[i].exp_lat, vecs[i].hold);
    end

    // Flush in the cycle the multiplier start would fire.
    ms0 = mul_starts;
    @(negedge clk);
    apply_stimulus(3'd0, 32'd3, 32'd4, 5'd20);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    flush = 1'b1;
    #1;
    check_output("flush_start.mul_start", {63'b0, mul_start}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check_output("flush_start.idle", {61'b0, bus.req_ready, bus.rsp_valid, stall}, 64'd4);
    check_output("flush_start.no_pulse", 64'(mul_starts - ms0), 64'd0);

    // Flush while the divider is running.
    @(negedge clk);
    apply_stimulus(3'd4, 32'd1000, 32'd9, 5'd21);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("flush_div.idle", {61'b0, bus.req_ready, bus.rsp_valid, stall}, 64'd4);
    seen = 0;
    repeat (DIV_LAT + 5) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check_output("flush_div.no_rsp", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    apply_stimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd22);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("reset_mid_mul");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: ra = MIN_NEG;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom), ref_result(rop, ra, rb),
             ref_latency(rop, ra, rb), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
